// File: rtl/multiplexed_hex_display.sv
// ---------------------------------------------------------------------------
// multiplexed_hex_display
//
// Self-scanning driver for an N-digit common-anode seven-segment display.
// One digit is driven per slot of REFRESH_DIV clocks. Every slot starts with
// BLANK_CYCLES of all-off guard time so the previous digit's pattern cannot
// ghost onto the next anode. The displayed values come from a snapshot taken
// at the start of every frame, so a frame never shows a half-updated value.
//
// Ports:
//   CLK            system clock
//   RESET_N        asynchronous active-low reset
//   DIGITS         packed hex digits, digit i = DIGITS[4i+3:4i]
//   DOTS           decimal point request per digit (1 = lit)
//   DIGIT_ENABLE   per-digit enable (1 = digit may be lit)
//   HEX_TO_CELL    active-low cathodes {dp, g, f, e, d, c, b, a}
//   SEGMENT_SELECT active-low anode select, one bit per digit
//   FRAME_START    one-cycle pulse when the scan re-enters digit 0, count 0
// ---------------------------------------------------------------------------
module multiplexed_hex_display #(
    parameter int NUM_DIGITS         = 4,
    parameter int REFRESH_DIV        = 100000,
    parameter int BLANK_CYCLES       = 1000,
    parameter int LEADING_ZERO_BLANK = 0
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [4*NUM_DIGITS-1:0]   DIGITS,
    input  logic [NUM_DIGITS-1:0]     DOTS,
    input  logic [NUM_DIGITS-1:0]     DIGIT_ENABLE,
    output logic [7:0]                HEX_TO_CELL,
    output logic [NUM_DIGITS-1:0]     SEGMENT_SELECT,
    output logic                      FRAME_START
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      BLANK_CNT = CNT_W'(BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);

    // Active-low {g..a} pattern for one hex digit.
    function automatic logic [6:0] decode_hex(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [IDX_W-1:0]        idx_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [4*NUM_DIGITS-1:0] snap_digits_r;
    logic [NUM_DIGITS-1:0]   snap_dots_r;
    logic [NUM_DIGITS-1:0]   snap_en_r;
    logic [7:0]              hex_r;
    logic [NUM_DIGITS-1:0]   sel_r;
    logic                    frame_start_r;

    logic [IDX_W-1:0]        idx_next_s;
    logic [CNT_W-1:0]        cnt_next_s;
    logic                    frame_start_s;
    logic [4*NUM_DIGITS-1:0] snap_digits_next_s;
    logic [NUM_DIGITS-1:0]   snap_dots_next_s;
    logic [NUM_DIGITS-1:0]   snap_en_next_s;
    logic [NUM_DIGITS-1:0]   lz_blank_s;
    logic                    zero_run_s;
    logic [3:0]              cur_digit_s;
    logic                    lit_s;
    logic [7:0]              hex_next_s;
    logic [NUM_DIGITS-1:0]   sel_next_s;

    // Slot counter and digit index advance; a wrap out of the last digit starts a frame.
    always_comb begin
        cnt_next_s    = cnt_r + CNT_ONE;
        idx_next_s    = idx_r;
        frame_start_s = 1'b0;
        if (cnt_r == CNT_LAST) begin
            cnt_next_s = {CNT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_next_s    = {IDX_W{1'b0}};
                frame_start_s = 1'b1;
            end else begin
                idx_next_s = idx_r + IDX_ONE;
            end
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Snapshot contents for the next cycle: fresh inputs at a frame start, else held.
    always_comb begin
        snap_digits_next_s = snap_digits_r;
        snap_dots_next_s   = snap_dots_r;
        snap_en_next_s     = snap_en_r;
        if (frame_start_s) begin
            snap_digits_next_s = DIGITS;
            snap_dots_next_s   = DOTS;
            snap_en_next_s     = DIGIT_ENABLE;
        end else begin
            snap_digits_next_s = snap_digits_r;
            snap_dots_next_s   = snap_dots_r;
            snap_en_next_s     = snap_en_r;
        end
    end

    // Leading-zero mask: walk from the top digit down while every digit seen is zero.
    // Digit 0 is excluded so an all-zero value still shows a single "0".
    always_comb begin
        zero_run_s = 1'b1;
        lz_blank_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s    = zero_run_s & (snap_digits_next_s[4*i +: 4] == 4'h0);
            lz_blank_s[i] = (LEADING_ZERO_BLANK != 0) && (i > 0) && zero_run_s;
        end
    end

    // Output pattern for the (idx, cnt) the registers move to, so outputs carry no extra latency.
    always_comb begin
        cur_digit_s = snap_digits_next_s[4*int'(idx_next_s) +: 4];
        lit_s       = snap_en_next_s[idx_next_s] & ~lz_blank_s[idx_next_s];
        sel_next_s  = {NUM_DIGITS{1'b1}};
        hex_next_s  = 8'hFF;
        if ((cnt_next_s >= BLANK_CNT) && lit_s) begin
            sel_next_s = ~(SEL_ONE << idx_next_s);
            hex_next_s = {~snap_dots_next_s[idx_next_s], decode_hex(cur_digit_s)};
        end else begin
            sel_next_s = {NUM_DIGITS{1'b1}};
            hex_next_s = 8'hFF;
        end
    end

    // Scan position and frame snapshot registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            idx_r         <= {IDX_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            snap_digits_r <= {(4*NUM_DIGITS){1'b0}};
            snap_dots_r   <= {NUM_DIGITS{1'b0}};
            snap_en_r     <= {NUM_DIGITS{1'b0}};
        end else begin
            idx_r         <= idx_next_s;
            cnt_r         <= cnt_next_s;
            snap_digits_r <= snap_digits_next_s;
            snap_dots_r   <= snap_dots_next_s;
            snap_en_r     <= snap_en_next_s;
        end
    end

    // Registered display outputs; reset drives everything to the all-off state at once.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hex_r         <= 8'hFF;
            sel_r         <= {NUM_DIGITS{1'b1}};
            frame_start_r <= 1'b0;
        end else begin
            hex_r         <= hex_next_s;
            sel_r         <= sel_next_s;
            frame_start_r <= frame_start_s;
        end
    end

    assign HEX_TO_CELL    = hex_r;
    assign SEGMENT_SELECT = sel_r;
    assign FRAME_START    = frame_start_r;

endmodule

// File: tb/tb_multiplexed_hex_display.sv
// ---------------------------------------------------------------------------
// tb_multiplexed_hex_display
//
// Directed bench for multiplexed_hex_display with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. Two instances share all inputs: dut_plain without and
// dut_lz with leading-zero blanking. Outputs are sampled 1 ns after the
// rising edge and compared as one packed word {FRAME_START, SEGMENT_SELECT,
// HEX_TO_CELL} against hand-computed values.
// ---------------------------------------------------------------------------
module tb_multiplexed_hex_display;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dots;
    logic [3:0]  digit_enable;

    logic [7:0]  hex_plain;
    logic [3:0]  sel_plain;
    logic        fs_plain;
    logic [7:0]  hex_lz;
    logic [3:0]  sel_lz;
    logic        fs_lz;

    int n_checks;
    int n_errors;

    multiplexed_hex_display #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LEADING_ZERO_BLANK(0)
    ) dut_plain (
        .CLK(clk), .RESET_N(rst_n), .DIGITS(digits), .DOTS(dots),
        .DIGIT_ENABLE(digit_enable), .HEX_TO_CELL(hex_plain),
        .SEGMENT_SELECT(sel_plain), .FRAME_START(fs_plain)
    );

    multiplexed_hex_display #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LEADING_ZERO_BLANK(1)
    ) dut_lz (
        .CLK(clk), .RESET_N(rst_n), .DIGITS(digits), .DOTS(dots),
        .DIGIT_ENABLE(digit_enable), .HEX_TO_CELL(hex_lz),
        .SEGMENT_SELECT(sel_lz), .FRAME_START(fs_lz)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, errors=%0d", n_errors);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {fs,sel,hex}=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] observe(input bit use_lz);
        return use_lz ? {fs_lz, sel_lz, hex_lz} : {fs_plain, sel_plain, hex_plain};
    endfunction

    // Checks the 31 cycles after reset release (frame start comes at the 32nd edge).
    task automatic blank_first_frame(input string tag);
        for (int k = 1; k < 32; k++) begin
            step();
            check_val({tag, "_plain"}, observe(1'b0), {1'b0, 4'hF, 8'hFF});
            check_val({tag, "_lz"},    observe(1'b1), {1'b0, 4'hF, 8'hFF});
        end
    endtask

    // Caller has just stepped onto a frame-start edge. Checks all 32 cycles of
    // the frame. hexes = {h3,h2,h1,h0}. At cycle chg_k (if >= 0) DIGITS is
    // changed to chg_val after sampling. Leaves the bench at cycle 31.
    task automatic run_frame(input string tag, input bit use_lz, input logic [31:0] hexes,
                             input logic [3:0] lit, input int chg_k, input logic [15:0] chg_val);
        logic [3:0]  one;
        logic [12:0] exp;
        int slot;
        int c;
        one = 4'b0001;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) step();
            slot = k / 8;
            c    = k % 8;
            exp  = {(k == 0) ? 1'b1 : 1'b0, 4'hF, 8'hFF};
            if (c >= 2 && lit[slot]) begin
                exp[11:8] = ~(one << slot);
                exp[7:0]  = hexes[slot*8 +: 8];
            end
            check_val(tag, observe(use_lz), exp);
            if (k == chg_k) digits = chg_val;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        digits       = 16'h0000;
        dots         = 4'h0;
        digit_enable = 4'h0;
        rst_n        = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_val("reset_plain", observe(1'b0), {1'b0, 4'hF, 8'hFF});
        check_val("reset_lz",    observe(1'b1), {1'b0, 4'hF, 8'hFF});
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;

        // Inputs change during the first frame but must stay hidden by the empty snapshot.
        digits       = 16'h3210;
        digit_enable = 4'hF;
        dots         = 4'h0;
        blank_first_frame("first_frame");

        step();
        run_frame("scan_3210", 1'b0, {8'hB0, 8'hA4, 8'hF9, 8'hC0}, 4'hF, -1, 16'h0000);

        digits = 16'hFEDC;
        dots   = 4'b0101;
        step();
        run_frame("letters_fedc", 1'b0, {8'h8E, 8'h06, 8'hA1, 8'h46}, 4'hF, -1, 16'h0000);

        digits = 16'hBA98;
        step();
        run_frame("letters_ba98", 1'b0, {8'h83, 8'h08, 8'h90, 8'h00}, 4'hF, -1, 16'h0000);

        // Mid-frame change during digit 1's slot must not show until the next frame.
        digits = 16'h1111;
        dots   = 4'h0;
        step();
        run_frame("snap_hold", 1'b0, {8'hF9, 8'hF9, 8'hF9, 8'hF9}, 4'hF, 10, 16'h2222);
        step();
        run_frame("snap_next", 1'b0, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 4'hF, -1, 16'h0000);

        digits = 16'h0050;
        step();
        run_frame("lz_0050", 1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0}, 4'b0011, -1, 16'h0000);

        digits = 16'h0000;
        step();
        run_frame("lz_0000", 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4'b0001, -1, 16'h0000);

        digits       = 16'h0005;
        digit_enable = 4'hE;
        step();
        run_frame("lz_0005_en_e", 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'b0000, -1, 16'h0000);

        // Async reset at digit 2, count 4, between clock edges.
        digits       = 16'h3210;
        digit_enable = 4'hF;
        step();
        check_val("pre_async_fs", observe(1'b0), {1'b1, 4'hF, 8'hFF});
        for (int k = 1; k <= 20; k++) step();
        check_val("pre_async_d2", observe(1'b0), {1'b0, 4'hB, 8'hA4});
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_plain", observe(1'b0), {1'b0, 4'hF, 8'hFF});
        check_val("async_rst_lz",    observe(1'b1), {1'b0, 4'hF, 8'hFF});
        step();
        @(negedge clk);
        rst_n = 1'b1;
        blank_first_frame("post_rst_frame");
        step();
        run_frame("post_rst_scan", 1'b0, {8'hB0, 8'hA4, 8'hF9, 8'hC0}, 4'hF, -1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
